mbinit_repairclk_wrapper: RTL and testbench
===========================================

# mbinit_repairclk_wrapper

Sideband-driven controller for the MBINIT.REPAIRCLK step of link training, one instance per die. It sequences the local request path: init, clock-pattern, result and done. It also runs the response path that answers the partner die's requests. All messages are exchanged as encoded sideband messages. It sits between the MBINIT top-level FSM, the sideband encoder/decoder and the clock-lane pattern generator/comparator.

## Interface
- SB_MSG_Width, 4: width of encoded/decoded sideband message IDs.
- TIMEOUT_CYCLES, 8000: handshake timeout, used only with the timeout feature.
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_mbinit_rpairclk_en  in  1  step enable; low forces IDLE.
- i_clk_ptrn_done  in  1  pattern generator finished.
- i_decoded_sb_msg  in  SB_MSG_Width  partner message ID.
- i_sb_valid  in  1  i_decoded_sb_msg valid (1-cycle pulse).
- i_sb_busy  in  1  sideband TX busy.
- i_falling_edge_busy  in  1  pulse: previous TX message fully sent.
- i_logged_results_SB  in  3  partner's compare results (RTRK,RCKN,RCKP), valid with result_resp.
- i_logged_results_COMP  in  3  local comparator results.
- o_encoded_sb_msg  out  SB_MSG_Width  message ID to send.
- o_msg_valid  out  1  1-cycle send strobe.
- o_error_req  out  1  request TRAINERROR.
- o_clk_ptrn_en  out  1  enable clock-pattern transmit.
- o_MBINIT_REPAIRCLK_end  out  1  step complete.
- o_logged_rx  out  3  local results sent with result_resp.
- o_clear_log  out  1  1-cycle comparator-log clear.

## Operation
- Message IDs: init_req=1, init_resp=2, result_req=3, result_resp=4, done_req=5, done_resp=6; 0 = none.
- TX FSM: IDLE -> SEND_INIT_REQ -> WAIT_INIT_RESP -> PATTERN -> SEND_RESULT_REQ -> WAIT_RESULT_RESP -> SEND_DONE_REQ -> WAIT_DONE_RESP -> TX_DONE; ERROR reachable from any WAIT state.
- RX FSM: IDLE -> WAIT_INIT_REQ -> SEND_INIT_RESP -> WAIT_RESULT_REQ -> SEND_RESULT_RESP -> WAIT_DONE_REQ -> SEND_DONE_RESP -> RX_DONE.
- Receiving init_req: pulse o_clear_log, queue init_resp.
- init_resp received: o_clk_ptrn_en=1 until i_clk_ptrn_done=1. Then the block queues result_req.
- Receiving result_req: capture i_logged_results_COMP into o_logged_rx (held), queue result_resp.
- result_resp received: if i_logged_results_SB==3'b111, queue done_req; otherwise go to ERROR.
- Receiving done_req: queue done_resp.
- o_MBINIT_REPAIRCLK_end=1 once TX_DONE (done_resp received) and RX_DONE (done_resp sent, falling edge seen); held until enable low.
- ERROR: o_error_req=1, held until enable low.
- Unexpected message IDs are ignored.

## Timing
- Reset: all outputs 0, both FSMs IDLE.
- Enable rise -> init_req strobe 1 cycle later.
- A message is issued only when the sender is not awaiting i_falling_edge_busy and i_sb_busy=0. o_msg_valid is high exactly 1 cycle. o_encoded_sb_msg holds until the next send.
- After each strobe the sender waits for i_falling_edge_busy before it issues the next message.
- If a queued response and a queued request are ready in the same cycle, the response goes first and the request follows the next falling edge.
- Response strobe occurs ≥1 cycle after the triggering i_sb_valid.
- Enable low mid-sequence: both FSMs go to IDLE next cycle, outputs clear, queues flush.
- Async reset mid-operation: immediate return to reset values.

## Configuration
- REPAIRCLK_TIMEOUT_EN defined: the counter restarts on each state change. If TIMEOUT_CYCLES elapse in any WAIT/PATTERN state, the block goes to ERROR (o_error_req=1).
- Not defined: no counter, and WAIT states wait indefinitely.

## Test plan
- Two instances cross-connected, both enabled, busy pulses per send -> each sends init_req(1) then init_resp(2); o_clear_log pulses once each.
- Clock-pattern phase: after init_resp, o_clk_ptrn_en=1; set i_clk_ptrn_done=1 -> result_req(3) within 3 cycles, o_clk_ptrn_en=0.
- i_logged_results_COMP=3'b111 both sides -> result_resp(4), o_logged_rx=3'b111, then done_req(5), done_resp(6), both o_MBINIT_REPAIRCLK_end=1.
- Partner reports 3'b101 -> o_error_req=1 on the receiver, no done_req sent.
- Enable dropped after init_resp -> all outputs 0 next cycle; re-enable -> init_req again.
- With REPAIRCLK_TIMEOUT_EN and no partner -> o_error_req=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/mbinit_repairclk_wrapper.sv
// MBINIT.REPAIRCLK request/response sideband sequencer, one per die.
// Optional handshake timeout is built when REPAIRCLK_TIMEOUT_EN is defined.
module mbinit_repairclk_wrapper #(
    parameter int SB_MSG_Width   = 4,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_mbinit_rpairclk_en,
    input  logic                    i_clk_ptrn_done,
    input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
    input  logic                    i_sb_valid,
    input  logic                    i_sb_busy,
    input  logic                    i_falling_edge_busy,
    input  logic [2:0]              i_logged_results_SB,
    input  logic [2:0]              i_logged_results_COMP,
    output logic [SB_MSG_Width-1:0] o_encoded_sb_msg,
    output logic                    o_msg_valid,
    output logic                    o_error_req,
    output logic                    o_clk_ptrn_en,
    output logic                    o_MBINIT_REPAIRCLK_end,
    output logic [2:0]              o_logged_rx,
    output logic                    o_clear_log
);
    localparam logic [SB_MSG_Width-1:0] MSG_INIT_REQ    = SB_MSG_Width'(1);
    localparam logic [SB_MSG_Width-1:0] MSG_INIT_RESP   = SB_MSG_Width'(2);
    localparam logic [SB_MSG_Width-1:0] MSG_RESULT_REQ  = SB_MSG_Width'(3);
    localparam logic [SB_MSG_Width-1:0] MSG_RESULT_RESP = SB_MSG_Width'(4);
    localparam logic [SB_MSG_Width-1:0] MSG_DONE_REQ    = SB_MSG_Width'(5);
    localparam logic [SB_MSG_Width-1:0] MSG_DONE_RESP   = SB_MSG_Width'(6);

    typedef enum logic [3:0] {
        TX_IDLE, TX_SEND_INIT_REQ, TX_WAIT_INIT_RESP, TX_PATTERN,
        TX_SEND_RESULT_REQ, TX_WAIT_RESULT_RESP, TX_SEND_DONE_REQ,
        TX_WAIT_DONE_RESP, TX_DONE, TX_ERROR
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_WAIT_INIT_REQ, RX_SEND_INIT_RESP, RX_WAIT_RESULT_REQ,
        RX_SEND_RESULT_RESP, RX_WAIT_DONE_REQ, RX_SEND_DONE_RESP, RX_DONE
    } rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic en;
    logic await_fe;
    logic can_send, tx_send, rx_send, tx_grant, rx_grant;
    logic [SB_MSG_Width-1:0] tx_msg, rx_msg;
    logic hit_init_req, hit_init_resp, hit_result_req;
    logic hit_result_resp, hit_done_req, hit_done_resp;

    assign en              = i_mbinit_rpairclk_en;
    assign hit_init_req    = i_sb_valid && (i_decoded_sb_msg == MSG_INIT_REQ);
    assign hit_init_resp   = i_sb_valid && (i_decoded_sb_msg == MSG_INIT_RESP);
    assign hit_result_req  = i_sb_valid && (i_decoded_sb_msg == MSG_RESULT_REQ);
    assign hit_result_resp = i_sb_valid && (i_decoded_sb_msg == MSG_RESULT_RESP);
    assign hit_done_req    = i_sb_valid && (i_decoded_sb_msg == MSG_DONE_REQ);
    assign hit_done_resp   = i_sb_valid && (i_decoded_sb_msg == MSG_DONE_RESP);

`ifdef REPAIRCLK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;
    logic waiting, timed_out;

    assign waiting = (tx_state inside {TX_WAIT_INIT_RESP, TX_PATTERN,
                                       TX_WAIT_RESULT_RESP, TX_WAIT_DONE_RESP})
                  || (rx_state inside {RX_WAIT_INIT_REQ, RX_WAIT_RESULT_REQ,
                                       RX_WAIT_DONE_REQ});
    assign timed_out = waiting && (to_cnt >= CW'(TIMEOUT_CYCLES - 1));

    // Restarts whenever either FSM moves, so it measures time spent in one state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            to_cnt <= '0;
        else if (!en || tx_next != tx_state || rx_next != rx_state)
            to_cnt <= '0;
        else if (waiting && !timed_out)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        if (!en) begin
            tx_next = TX_IDLE;
        end else begin
            unique case (tx_state)
                TX_IDLE:             tx_next = TX_SEND_INIT_REQ;
                TX_SEND_INIT_REQ:    if (tx_grant) tx_next = TX_WAIT_INIT_RESP;
                TX_WAIT_INIT_RESP:   if (hit_init_resp) tx_next = TX_PATTERN;
                TX_PATTERN:          if (i_clk_ptrn_done) tx_next = TX_SEND_RESULT_REQ;
                TX_SEND_RESULT_REQ:  if (tx_grant) tx_next = TX_WAIT_RESULT_RESP;
                TX_WAIT_RESULT_RESP:
                    if (hit_result_resp)
                        tx_next = (i_logged_results_SB == 3'b111) ? TX_SEND_DONE_REQ
                                                                  : TX_ERROR;
                TX_SEND_DONE_REQ:    if (tx_grant) tx_next = TX_WAIT_DONE_RESP;
                TX_WAIT_DONE_RESP:   if (hit_done_resp) tx_next = TX_DONE;
                TX_DONE:             tx_next = TX_DONE;
                TX_ERROR:            tx_next = TX_ERROR;
                default:             tx_next = TX_IDLE;
            endcase
`ifdef REPAIRCLK_TIMEOUT_EN
            if (timed_out) tx_next = TX_ERROR;
`endif
        end
    end

    always_comb begin
        rx_next = rx_state;
        if (!en) begin
            rx_next = RX_IDLE;
        end else begin
            unique case (rx_state)
                RX_IDLE:             rx_next = RX_WAIT_INIT_REQ;
                RX_WAIT_INIT_REQ:    if (hit_init_req) rx_next = RX_SEND_INIT_RESP;
                RX_SEND_INIT_RESP:   if (rx_grant) rx_next = RX_WAIT_RESULT_REQ;
                RX_WAIT_RESULT_REQ:  if (hit_result_req) rx_next = RX_SEND_RESULT_RESP;
                RX_SEND_RESULT_RESP: if (rx_grant) rx_next = RX_WAIT_DONE_REQ;
                RX_WAIT_DONE_REQ:    if (hit_done_req) rx_next = RX_SEND_DONE_RESP;
                RX_SEND_DONE_RESP:   if (rx_grant) rx_next = RX_DONE;
                RX_DONE:             rx_next = RX_DONE;
            endcase
        end
    end

    // Shared sideband port: a pending response always wins over a request.
    always_comb begin
        tx_send = 1'b0;
        tx_msg  = '0;
        rx_send = 1'b0;
        rx_msg  = '0;
        unique case (tx_state)
            TX_SEND_INIT_REQ:   begin tx_send = 1'b1; tx_msg = MSG_INIT_REQ;   end
            TX_SEND_RESULT_REQ: begin tx_send = 1'b1; tx_msg = MSG_RESULT_REQ; end
            TX_SEND_DONE_REQ:   begin tx_send = 1'b1; tx_msg = MSG_DONE_REQ;   end
            default: ;
        endcase
        unique case (rx_state)
            RX_SEND_INIT_RESP:   begin rx_send = 1'b1; rx_msg = MSG_INIT_RESP;   end
            RX_SEND_RESULT_RESP: begin rx_send = 1'b1; rx_msg = MSG_RESULT_RESP; end
            RX_SEND_DONE_RESP:   begin rx_send = 1'b1; rx_msg = MSG_DONE_RESP;   end
            default: ;
        endcase
        can_send = en && !await_fe && !i_sb_busy;
        rx_grant = can_send && rx_send;
        tx_grant = can_send && tx_send && !rx_send;
        o_clk_ptrn_en = (tx_state == TX_PATTERN);
        o_error_req   = (tx_state == TX_ERROR);
        o_MBINIT_REPAIRCLK_end = (tx_state == TX_DONE) && (rx_state == RX_DONE)
                              && !await_fe;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || !en) begin
            o_encoded_sb_msg <= '0;
            o_msg_valid      <= 1'b0;
            o_clear_log      <= 1'b0;
            o_logged_rx      <= '0;
            await_fe         <= 1'b0;
        end else begin
            o_msg_valid <= rx_grant || tx_grant;
            if (rx_grant)
                o_encoded_sb_msg <= rx_msg;
            else if (tx_grant)
                o_encoded_sb_msg <= tx_msg;
            if (rx_grant || tx_grant)
                await_fe <= 1'b1;
            else if (i_falling_edge_busy)
                await_fe <= 1'b0;
            o_clear_log <= (rx_state == RX_WAIT_INIT_REQ) && hit_init_req;
            if (rx_state == RX_WAIT_RESULT_REQ && hit_result_req)
                o_logged_rx <= i_logged_results_COMP;
        end
    end
endmodule

// File: tb/tb_mbinit_repairclk_wrapper.sv
// Bench: plays the partner die and the sideband TX channel around one DUT.
// Expected traffic is derived from the REPAIRCLK message rules.
module tb_mbinit_repairclk_wrapper;
    logic       clk = 1'b0;
    logic       rst, en, ptrn_done, sb_valid, sb_busy, fe;
    logic [3:0] dec_msg;
    logic [2:0] res_sb, res_comp;
    logic [3:0] enc_msg;
    logic       msg_valid, error_req, ptrn_en, step_end, clear_log;
    logic [2:0] logged_rx;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] sent_q[$];
    logic       em_active = 1'b0;

    always #5 clk = ~clk;

    mbinit_repairclk_wrapper dut (
        .i_clk(clk), .i_rst(rst), .i_mbinit_rpairclk_en(en),
        .i_clk_ptrn_done(ptrn_done), .i_decoded_sb_msg(dec_msg),
        .i_sb_valid(sb_valid), .i_sb_busy(sb_busy),
        .i_falling_edge_busy(fe), .i_logged_results_SB(res_sb),
        .i_logged_results_COMP(res_comp), .o_encoded_sb_msg(enc_msg),
        .o_msg_valid(msg_valid), .o_error_req(error_req),
        .o_clk_ptrn_en(ptrn_en), .o_MBINIT_REPAIRCLK_end(step_end),
        .o_logged_rx(logged_rx), .o_clear_log(clear_log)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({enc_msg, msg_valid, error_req, ptrn_en, step_end,
                    logged_rx, clear_log});
    endfunction

    task automatic wait_msg(input logic [3:0] exp, input int budget,
                            input string tag);
        int n = 0;
        while (sent_q.size() == 0 && n < budget) begin
            step();
            n++;
        end
        if (sent_q.size() == 0)
            check(tag, 32'hDEAD, 32'(exp));
        else
            check(tag, 32'(sent_q.pop_front()), 32'(exp));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (em_active && n < 50) begin
            step();
            n++;
        end
        check("channel_idle", 32'(em_active), 0);
    endtask

    task automatic send_partner(input logic [3:0] id);
        dec_msg  = id;
        sb_valid = 1'b1;
        step();
        sb_valid = 1'b0;
        dec_msg  = '0;
    endtask

    task automatic disable_step();
        en = 1'b0;
        step();
        check("disable_clears", all_outs(), 0);
        wait_idle();
        sent_q.delete();
    endtask

    // Enable through the point where the clock pattern is running.
    task automatic start_to_pattern();
        wait_idle();
        sent_q.delete();
        en = 1'b1;
        step();
        step();
        check("init_req_strobe", 32'({msg_valid, enc_msg}), 32'(5'h11));
        wait_msg(4'd1, 5, "init_req");
        send_partner(4'd1);
        check("clear_log_pulse", 32'(clear_log), 1);
        step();
        check("clear_log_single", 32'(clear_log), 0);
        wait_msg(4'd2, 20, "init_resp");
        send_partner(4'd2);
        check("ptrn_en_on", 32'(ptrn_en), 1);
    endtask

    task automatic run_trial(input bit together, input bit sb_good,
                             input logic [2:0] comp);
        logic [2:0] sb;
        sb = sb_good ? 3'b111 : 3'($urandom_range(0, 6));
        start_to_pattern();
        res_sb = 3'b111;
        send_partner(4'd7);
        send_partner(4'd4);
        repeat ($urandom_range(0, 5)) step();
        wait_idle();
        check("ignore_unexpected", 32'({ptrn_en, error_req}), 32'(2'b10));
        check("no_spurious_msg", 32'(sent_q.size()), 0);
        res_comp = comp;
        if (together) begin
            ptrn_done = 1'b1;
            send_partner(4'd3);
            ptrn_done = 1'b0;
            check("logged_rx", 32'(logged_rx), 32'(comp));
            wait_msg(4'd4, 20, "resp_first");
            wait_msg(4'd3, 20, "req_after_resp");
        end else begin
            ptrn_done = 1'b1;
            step();
            ptrn_done = 1'b0;
            wait_msg(4'd3, 3, "result_req_fast");
            check("ptrn_en_off", 32'(ptrn_en), 0);
            send_partner(4'd3);
            check("logged_rx", 32'(logged_rx), 32'(comp));
            wait_msg(4'd4, 20, "result_resp");
        end
        check("ptrn_en_off2", 32'(ptrn_en), 0);
        res_comp = ~comp;
        res_sb = sb;
        send_partner(4'd4);
        if (sb == 3'b111) begin
            check("no_error", 32'(error_req), 0);
            wait_msg(4'd5, 20, "done_req");
            send_partner(4'd5);
            wait_msg(4'd6, 20, "done_resp");
            send_partner(4'd6);
            for (int n = 0; n < 30 && step_end !== 1'b1; n++) step();
            check("step_end", 32'(step_end), 1);
            step();
            step();
            check("step_end_held", 32'({step_end, error_req}), 32'(2'b10));
            check("logged_rx_held", 32'(logged_rx), 32'(comp));
        end else begin
            check("error_req", 32'(error_req), 1);
            repeat (10) step();
            check("error_held", 32'({error_req, step_end}), 32'(2'b10));
            check("no_done_req", 32'(sent_q.size()), 0);
        end
        disable_step();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        ptrn_done = 1'b0;
        sb_valid = 1'b0;
        sb_busy = 1'b0;
        fe = 1'b0;
        dec_msg = '0;
        res_sb = '0;
        res_comp = '0;
        // Sideband TX channel: busy for a random span after every strobe.
        fork
            forever begin
                step();
                if (msg_valid === 1'b1) begin
                    em_active = 1'b1;
                    sent_q.push_back(enc_msg);
                    sb_busy = 1'b1;
                    repeat ($urandom_range(1, 4)) begin
                        step();
                        check("single_strobe", 32'(msg_valid), 0);
                    end
                    sb_busy = 1'b0;
                    fe = 1'b1;
                    step();
                    check("no_strobe_at_fe", 32'(msg_valid), 0);
                    fe = 1'b0;
                    em_active = 1'b0;
                end
            end
        join_none
        step();
        step();
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        step();
        check("idle_disabled", all_outs(), 0);

        for (int t = 0; t < 8; t++)
            run_trial(t[0], (t < 2) ? (t == 0) : bit'($urandom_range(0, 1)),
                      3'($urandom));

        start_to_pattern();
        disable_step();
        repeat (3) step();
        check("stay_idle", all_outs(), 0);

        start_to_pattern();
        #2 rst = 1'b1;
        #1 check("async_reset", all_outs(), 0);
        en = 1'b0;
        step();
        rst = 1'b0;
        wait_idle();
        sent_q.delete();
        run_trial(1'b0, 1'b1, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
